// File: rtl/neopixel_pkg.sv
// Shared types and default 50 MHz bit timing for the NeoPixel chain driver.
package neopixel_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;
  typedef enum logic [1:0] {GREEN = 2'd0, RED = 2'd1, BLUE = 2'd2} color_t;

  localparam int DEF_NUM_PIXELS = 5;
  localparam int DEF_T0H        = 18;
  localparam int DEF_T0L        = 44;
  localparam int DEF_T1H        = 35;
  localparam int DEF_T1L        = 27;
  localparam int DEF_T_LATCH    = 2500;
  localparam int BITS_PER_PIXEL = 24;

  // Cycle counters must hold the longest phase the design ever counts.
  function automatic int cnt_width(input int t_latch, input int t0l, input int t1h);
    int m;
    m = t_latch;
    if (t0l > m) m = t0l;
    if (t1h > m) m = t1h;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/neo_bit_timer.sv
// Generates one pixel bit: high phase, then low phase, then a bit_done pulse.
// A start on the bit_done cycle chains the next bit with no gap.
module neo_bit_timer
  import neopixel_pkg::*;
#(
  parameter int T0H   = DEF_T0H,
  parameter int T0L   = DEF_T0L,
  parameter int T1H   = DEF_T1H,
  parameter int T1L   = DEF_T1L,
  parameter int CNT_W = 12
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic bit_value,
  output logic level,
  output logic high_done,
  output logic bit_done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_last;
  logic [CNT_W-1:0] low_last;
  logic             bit_q;
  logic             busy;

  assign high_last = bit_q ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
  assign low_last  = bit_q ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);
  assign high_done = busy && level && (cnt == high_last);
  assign bit_done  = busy && !level && (cnt == low_last);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      bit_q <= 1'b0;
      level <= 1'b0;
      busy  <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      bit_q <= bit_value;
      level <= 1'b1;
      busy  <= 1'b1;
    end else if (high_done) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (bit_done) begin
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (busy) begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/neopixel_controller.sv
// WS2812 chain driver: byte-wide colour store, serial frame, latch interval.
// Define NEO_CLEAR_ON_SEND_EN to wipe the colour store at the end of each frame.
module neopixel_controller
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int T0H        = DEF_T0H,
  parameter int T0L        = DEF_T0L,
  parameter int T1H        = DEF_T1H,
  parameter int T1L        = DEF_T1L,
  parameter int T_LATCH    = DEF_T_LATCH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       load_color,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send
);

  localparam int CNT_W = cnt_width(T_LATCH, T0L, T1H);
  localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  state_t           state, state_next;
  logic [4:0]       bit_cnt, bit_next;
  logic [PIX_W-1:0] pix_cnt, pix_next;
  logic [CNT_W-1:0] latch_cnt;
  logic [7:0]       store [NUM_PIXELS][3];

  logic start, next_bit_value, high_done, bit_done;
  logic load_ok, last_bit, latch_done;

  assign load_ok = load_color && (state == IDLE) &&
                   (int'(pixel_index) < NUM_PIXELS) && (color_index != 2'd3);
  assign last_bit   = (pix_cnt == PIX_W'(NUM_PIXELS - 1)) && (bit_cnt == 5'd23);
  assign latch_done = (state == LATCH) && (latch_cnt == CNT_W'(T_LATCH - 1));

  assign ready_to_load = (state == IDLE);
  assign ready_to_send = (state == IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    bit_next   = bit_cnt;
    pix_next   = pix_cnt;
    unique case (state)
      IDLE: begin
        if (send_it) begin
          start      = 1'b1;
          state_next = HIGH;
          bit_next   = '0;
          pix_next   = '0;
        end
      end
      HIGH: if (high_done) state_next = LOW;
      LOW: begin
        if (bit_done) begin
          if (last_bit) begin
            state_next = LATCH;
          end else begin
            start      = 1'b1;
            state_next = HIGH;
            if (bit_cnt == 5'd23) begin
              bit_next = '0;
              pix_next = pix_cnt + 1'b1;
            end else begin
              bit_next = bit_cnt + 5'd1;
            end
          end
        end
      end
      LATCH: if (latch_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A byte loaded on the send edge is not in the store yet; forward its MSB.
  always_comb begin
    next_bit_value = store[pix_next][bit_next[4:3]][~bit_next[2:0]];
    if (state == IDLE && load_ok && pixel_index == 3'd0 && color_index == GREEN)
      next_bit_value = color_level[7];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      pix_cnt   <= '0;
      latch_cnt <= '0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_next;
      pix_cnt   <= pix_next;
      latch_cnt <= (state == LATCH && !latch_done) ? latch_cnt + 1'b1 : '0;
    end
  end

  // NOTE: the colour store is a small register file, not a RAM, because
  // reset must clear every byte; a RAM macro could not be reset this way.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIXELS; p++)
        for (int c = 0; c < 3; c++)
          store[p][c] <= '0;
    end else begin
      if (load_ok)
        store[pixel_index[PIX_W-1:0]][color_index] <= color_level;
`ifdef NEO_CLEAR_ON_SEND_EN
      if (latch_done)
        for (int p = 0; p < NUM_PIXELS; p++)
          for (int c = 0; c < 3; c++)
            store[p][c] <= '0;
`endif
    end
  end

  neo_bit_timer #(
    .T0H   (T0H),
    .T0L   (T0L),
    .T1H   (T1H),
    .T1L   (T1L),
    .CNT_W (CNT_W)
  ) u_bit_timer (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bit_value (next_bit_value),
    .level     (neo_data),
    .high_done (high_done),
    .bit_done  (bit_done)
  );

endmodule

// File: tb/tb_neopixel_controller.sv
// Self-checking bench for neopixel_controller: randomized colours against a
// byte-array model that expands each frame into its expected waveform.
module tb_neopixel_controller;

  localparam int NP      = 5;
  localparam int T0H     = 18;
  localparam int T0L     = 44;
  localparam int T1H     = 35;
  localparam int T1L     = 27;
  localparam int T_LATCH = 2500;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       load_color;
  logic       send_it;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model [NP][3];
  bit         exp_nd[$];
  bit         got_nd[$];
  bit         got_rdy[$];

  always #5 clock = ~clock;

  neopixel_controller #(
    .NUM_PIXELS (NP),
    .T0H        (T0H),
    .T0L        (T0L),
    .T1H        (T1H),
    .T1L        (T1L),
    .T_LATCH    (T_LATCH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .load_color    (load_color),
    .send_it       (send_it),
    .neo_data      (neo_data),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++)
        model[p][c] = 8'h00;
  endtask

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic do_load(input int p, input int c, input int v);
    @(negedge clock);
    pixel_index = p[2:0];
    color_index = c[1:0];
    color_level = v[7:0];
    load_color  = 1'b1;
    if (p < NP && c < 3) model[p][c] = v[7:0];
    @(negedge clock);
    load_color  = 1'b0;
  endtask

  // Sends one frame (optionally with a load on the same edge), records the
  // output once per cycle and compares it with the waveform the model predicts.
  task automatic run_frame(input string name, input bit with_load, input int lp,
                           input int lc, input int lv, input int inject_at);
    int  total, k, busy, err, bad, run;
    bit  done;
    bit  dq[$];
    logic [23:0] got24, exp24;

    @(negedge clock);
    if (with_load) begin
      pixel_index = lp[2:0];
      color_index = lc[1:0];
      color_level = lv[7:0];
      load_color  = 1'b1;
      if (lp < NP && lc < 3) model[lp][lc] = lv[7:0];
    end
    send_it = 1'b1;

    exp_nd.delete();
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++)
        for (int b = 7; b >= 0; b--) begin
          int th, tl;
          th = model[p][c][b] ? T1H : T0H;
          tl = model[p][c][b] ? T1L : T0L;
          repeat (th) exp_nd.push_back(1'b1);
          repeat (tl) exp_nd.push_back(1'b0);
        end
    repeat (T_LATCH) exp_nd.push_back(1'b0);
    total = exp_nd.size();

    got_nd.delete();
    got_rdy.delete();
    k    = 0;
    done = 1'b0;
    while (!done && k < total + 200) begin
      @(negedge clock);
      got_nd.push_back(neo_data);
      got_rdy.push_back(ready_to_load & ready_to_send);
      if (ready_to_load && ready_to_send && k > 0) done = 1'b1;
      if (k == 0) begin
        send_it    = 1'b0;
        load_color = 1'b0;
      end
      if (inject_at >= 0 && (k == inject_at || k == total - 10)) begin
        pixel_index = 3'd0;
        color_index = 2'd0;
        color_level = ~model[0][0];
        load_color  = 1'b1;
        send_it     = 1'b1;
      end else if (k > 0) begin
        load_color = 1'b0;
        send_it    = 1'b0;
      end
      k++;
    end

    check({name, ":timeout"}, done, 1);
    check({name, ":start_nd"}, got_nd[0], 1);
    check({name, ":start_rdy"}, got_rdy[0], 0);
    busy = done ? k - 1 : k;
    check({name, ":busy_len"}, busy, total);

    err = 0;
    for (int i = 0; i < busy && i < total; i++)
      if (got_nd[i] != exp_nd[i] || got_rdy[i] != 1'b0) err++;
    check({name, ":wave_err"}, err, 0);

    bad = 0;
    run = 0;
    for (int i = 0; i <= busy && i < got_nd.size(); i++) begin
      if (got_nd[i]) begin
        run++;
      end else if (run > 0) begin
        if (run != T0H && run != T1H) bad++;
        dq.push_back(run == T1H);
        run = 0;
      end
    end
    check({name, ":bad_high"}, bad, 0);
    check({name, ":nbits"}, dq.size(), NP * 24);
    for (int p = 0; p < NP; p++) begin
      got24 = '0;
      for (int i = 0; i < 24; i++)
        if (p * 24 + i < dq.size()) got24[23 - i] = dq[p * 24 + i];
      exp24 = {model[p][0], model[p][1], model[p][2]};
      check($sformatf("%s:pix%0d", name, p), got24, exp24);
    end

`ifdef NEO_CLEAR_ON_SEND_EN
    clear_model();
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_high;
    reset       = 1'b1;
    pixel_index = '0;
    color_index = '0;
    color_level = '0;
    load_color  = 1'b0;
    send_it     = 1'b0;
    clear_model();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst:neo_data", neo_data, 0);
    check("rst:ready_to_load", ready_to_load, 1);
    check("rst:ready_to_send", ready_to_send, 1);

    // First bit is a one (35 high), every other bit a zero (18 high).
    do_load(0, 0, 8'h80);
    run_frame("t2", 1'b0, 0, 0, 0, -1);
    first_high = 0;
    while (first_high < got_nd.size() && got_nd[first_high]) first_high++;
    check("t2:first_high", first_high, T1H);

    // Invalid loads are dropped; mid-frame load/send are ignored.
    do_load(0, 3, 8'h55);
    do_load(7, 0, 8'h55);
    do_load(5, 1, 8'hAA);
    run_frame("t34", 1'b0, 0, 0, 0, 100);

    // Random colours, then a load of pixel 0 blue on the send edge.
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < 3; c++)
        do_load(p, c, int'($urandom_range(0, 255)));
    run_frame("t5", 1'b0 | 1'b1, 0, 2, 8'hFF, -1);
    check("t5:blue0", {got_nd.size() > 0, 8'hFF}, {1'b1, model[0][2] | 8'hFF});

    // Reset 40 cycles into a frame of non-zero data.
    for (int c = 0; c < 3; c++)
      do_load(c + 1, c, int'($urandom_range(1, 255)));
    @(negedge clock);
    send_it = 1'b1;
    @(negedge clock);
    send_it = 1'b0;
    repeat (39) @(negedge clock);
    check("t6:mid_ready", ready_to_send, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6:rst_nd", neo_data, 0);
    check("t6:rst_ready_load", ready_to_load, 1);
    check("t6:rst_ready_send", ready_to_send, 1);
    clear_model();
    run_frame("t6a", 1'b0, 0, 0, 0, -1);
    run_frame("t6b", 1'b0, 0, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neopixel_controller.md
# neopixel_controller

Drives a serial chain of WS2812-style NeoPixels from a color store written one byte at a time. The pattern-generator FSM (Task2) sits on the other side of the load/send handshake. It waits for `ready_to_load` / `ready_to_send`, writes color bytes with `load_color`, then pulses `send_it`. This block stores the bytes, serialises the frame onto `neo_data` with the pixel bit-timing, then holds the latch-low interval before reporting ready again.

## Interface
- `NUM_PIXELS`, 5: pixels in the chain, 1..8.
- `T0H`, 18: high cycles for a 0 bit.
- `T0L`, 44: low cycles for a 0 bit.
- `T1H`, 35: high cycles for a 1 bit.
- `T1L`, 27: low cycles for a 1 bit.
- `T_LATCH`, 2500: low cycles ending a frame (50 µs at 50 MHz).

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `pixel_index`  in  3: pixel slot for a load.
- `color_index`  in  2: byte within the pixel: 0 = G, 1 = R, 2 = B; 3 is invalid.
- `color_level`  in  8: byte value.
- `load_color`  in  1: write strobe, one cycle per byte.
- `send_it`  in  1: start-frame strobe.
- `neo_data`  out  1: registered serial output to the pixel chain.
- `ready_to_load`  out  1: high only in IDLE.
- `ready_to_send`  out  1: high only in IDLE.

## Operation
- Storage: NUM_PIXELS × 3 bytes. Reset clears every byte to 0.
- Load: accepted only when `load_color`=1 and state is IDLE. A load is dropped if `pixel_index` ≥ NUM_PIXELS or `color_index`=3.
- States:
  - IDLE: both ready outputs = 1; `neo_data`=0.
  - HIGH: drives the high phase of the current bit.
  - LOW: drives the low phase of the current bit.
  - LATCH: holds `neo_data`=0 for T_LATCH cycles.
- Transitions:
  - IDLE→HIGH on `send_it`.
  - HIGH→LOW after T0H or T1H cycles, chosen by the current bit.
  - LOW→HIGH on the next bit after T0L or T1L cycles.
  - LOW→LATCH after the last bit.
  - LATCH→IDLE after T_LATCH cycles.
- Bit order: pixel 0 first, then ascending pixel index. Within a pixel: G, R, B. Within a byte: MSB first. Frame length is NUM_PIXELS × 24 bits.
- `send_it` outside IDLE is ignored. `load_color` outside IDLE is ignored, and the stored value is unchanged.
- Simultaneous `load_color` and `send_it` in IDLE: the load is written, and the frame transmits the new value.
- Stored bytes persist across frames unless the configuration macro below is defined.
- `reset` asserted mid-frame or mid-latch:
  - next state is IDLE; `neo_data`=0;
  - all counters are zeroed;
  - storage is cleared.

## Timing
- Reset values: `neo_data`=0, `ready_to_load`=1, `ready_to_send`=1.
- `send_it` sampled on edge N:
  - `ready_*` go low after edge N;
  - `neo_data` is 1 during cycle N+1 (registered output).
- Each bit's high phase is exactly T0H or T1H cycles. Its low phase is exactly T0L or T1L cycles.
- There are no gap cycles between consecutive bits.
- Frame duration from `neo_data` first rising to IDLE is the sum of all bit periods (Σ bit periods) + T_LATCH cycles. The readies rise on the cycle after the last latch cycle.
- Load latency: a byte written at edge N is visible to a frame started at edge N or later.
- Counters:
  - cycle counter: `$clog2(max(T_LATCH, T0L, T1H) + 1)` bits;
  - bit counter: 0..23;
  - pixel counter: 0..NUM_PIXELS−1.
  - No counter wraps within a frame.

## Configuration
- `NEO_CLEAR_ON_SEND_EN`:
  - Defined: every stored byte is cleared to 0 on the edge where LATCH→IDLE, so each frame needs fresh loads.
  - Undefined: bytes persist until overwritten or reset.
- Load/send timing is identical either way.

## Structure
- Package `neopixel_pkg` holds:
  - enum `state_t` {IDLE, HIGH, LOW, LATCH};
  - enum `color_t` {GREEN=0, RED=1, BLUE=2};
  - default timing constants at 50 MHz.
- One natural sub-module, `neo_bit_timer`: given a bit value and a start pulse, it generates the high/low phase and a `bit_done` pulse. The parent owns storage, sequencing and latch counting.

## Test plan
1. Reset, then idle 3 cycles → `neo_data`=0, both readies=1, all storage reads 0.
2. Load pixel 0 G=0x80, frame all-zeros otherwise, then `send_it` → `neo_data` high 35 cycles on the first bit, then 18 cycles high on each of the remaining 119 bits. The readies are low for the whole frame plus 2500 cycles.
3. Load with `color_index`=3 or `pixel_index`=7 (NUM_PIXELS=5) → storage unchanged; the next frame is identical to the previous one.
4. Pulse `load_color` and `send_it` again mid-frame → both ignored, and the frame bits match the pre-send contents.
5. Simultaneous `load_color` (pixel 0, B=0xFF) and `send_it` in IDLE → bits 16–23 of the frame are all 1 (T1H high).
6. Assert `reset` 40 cycles into a frame → `neo_data`=0 and readies=1 the next cycle; a subsequent send transmits all zeros. With `NEO_CLEAR_ON_SEND_EN` defined, a second send with no loads also transmits all zeros.
